matrix_entry_ctrl: RTL and testbench
====================================

MATRIX_ENTRY_CTRL -- requirements
Module: matrix_entry_ctrl

Interface
REQ-001 Parameter DIM, 3, matrix dimension; legal values are 2 and 3; element count N = DIM*DIM.
REQ-002 Parameter TIMEOUT_CYCLES, 24'd10_000_000, idle limit used only when the entry timeout is compiled in.
REQ-003 clk  in  1  clock, rising-edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 keycode  in  9  completed keypad code; valid in the cycle store_dig=1.
REQ-006 store_dig  in  1  one-cycle pulse: digit complete.
REQ-007 enter  in  1  one-cycle pulse: enter command.
REQ-008 result_ready  in  1  one-cycle pulse: compute command.
REQ-009 alu_done  in  1  level/pulse from the matrix ALU: operation finished.
REQ-010 wr_en  out  1  register-file write strobe.
REQ-011 wr_sel  out  1  target matrix: 0 = A, 1 = B.
REQ-012 wr_addr  out  4  element index, row-major, 0..N-1.
REQ-013 wr_data  out  9  element value.
REQ-014 alu_op  out  2  latched opcode: 00 add, 01 sub, 10 mul.
REQ-015 alu_start  out  1  one-cycle start pulse to the ALU.
REQ-016 phase  out  3  current state encoding, for display.
REQ-017 result_valid  out  1  result is stable for display.
REQ-018 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-019 The FSM SHALL have states LOAD_A, LOAD_B, GET_OP, START, WAIT, SHOW; encodings 0..5 SHALL drive phase.
REQ-020 Each store_dig in LOAD_A or LOAD_B while idx<N SHALL register wr_en=1, wr_addr=idx, wr_data=keycode and wr_sel per state on the next edge; idx then SHALL increment.
REQ-021 wr_en SHALL be high for exactly one cycle per accepted digit, with a latency of 1 cycle from store_dig.
REQ-022 A store_dig with idx==N SHALL be discarded: no write, err pulse.
REQ-023 An enter in LOAD_A or LOAD_B with idx==N SHALL clear idx and advance the state (LOAD_A->LOAD_B, LOAD_B->GET_OP).
REQ-024 An enter with idx<N SHALL be ignored and SHALL pulse err.
REQ-025 In GET_OP, store_dig SHALL latch alu_op=keycode[1:0]; keycode[1:0]==11 SHALL be rejected with an err pulse and leave alu_op unchanged.
REQ-026 result_ready in GET_OP SHALL move to START only if a valid opcode has been latched since GET_OP entry; otherwise it SHALL pulse err.
REQ-027 START SHALL assert alu_start for exactly one cycle, then move to WAIT.
REQ-028 WAIT SHALL stay until alu_done=1, then move to SHOW; alu_done outside WAIT SHALL be ignored.
REQ-029 result_valid SHALL be high in exactly the SHOW state.
REQ-030 enter in SHOW SHALL return to LOAD_A with idx=0 and the opcode-valid flag cleared.
REQ-031 If store_dig and enter are both high in one cycle, store_dig SHALL be processed and enter dropped.
REQ-032 result_ready outside GET_OP SHALL be ignored without err.

Reset
REQ-033 While nrst=0: state=LOAD_A, idx=0, alu_op=00, opcode-valid=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, alu_start=0, result_valid=0, err=0.
REQ-034 Reset mid-operation, including during WAIT, SHALL abandon the sequence with no further writes or starts.

Configuration
REQ-035 With ENTRY_TIMEOUT_EN defined, a counter SHALL clear on any input pulse and on every state change.
REQ-036 With ENTRY_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES in LOAD_A, LOAD_B or GET_OP, the block SHALL pulse err and return to its reset state.
REQ-037 With ENTRY_TIMEOUT_EN undefined, neither the counter nor the timeout path SHALL exist.

Structure
REQ-038 The state enum, the opcode constants (ADD, SUB, MUL) and the address width SHALL live in the shared package matrix_pkg.
REQ-039 The optional timeout counter SHALL be a sub-module named entry_timer.

Verification
REQ-040 Scenario: 9 store_dig pulses with keycodes 1..9 in LOAD_A -> 9 writes wr_sel=0, addr 0..8, data 1..9, each 1 cycle after its pulse.
REQ-041 Scenario: enter after 5 digits -> err pulse, still LOAD_A; 4 more digits then enter -> phase=1 (LOAD_B).
REQ-042 Scenario: full A and B, opcode keycode 9'h003 -> err; then 9'h002, then result_ready -> a single alu_start with alu_op=10; alu_done 20 cycles later -> result_valid=1.
REQ-043 Scenario: result_ready in GET_OP with no opcode -> err, still phase=2.
REQ-044 Scenario: store_dig and enter together in LOAD_A with idx=8 -> write at addr 8, no transition.
REQ-045 Scenario: nrst pulsed low in WAIT -> all outputs at reset values; a later alu_done produces no result_valid. With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=100, 100 idle cycles in LOAD_B -> err and phase=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix entry controller.
// Contents:
//   state_t        - controller states; the encoding is exported as 'phase'
//   ADD, SUB, MUL  - ALU opcodes latched from keycode[1:0]
//   ADDR_W         - width of the register-file element index
//   is_entry_state - true in the states where the user is typing
package matrix_pkg;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    GET_OP = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    SHOW   = 3'd5
  } state_t;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;

  localparam int ADDR_W = 4;

  function automatic logic is_entry_state(state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Idle counter for the optional entry timeout.
// Ports:
//   clk     in   clock, rising edge
//   nrst    in   asynchronous active-low reset
//   clear   in   restart counting from zero
//   expired out  counter has reached LIMIT (holds there until cleared)
module entry_timer #(
  parameter logic [23:0] LIMIT = 24'd10_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  output logic expired
);

  logic [23:0] count;

  // Saturate at LIMIT so a long stay in WAIT/SHOW cannot wrap around.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 24'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/matrix_entry_ctrl.sv
// Keypad-driven entry controller for a small matrix ALU.
// Collects DIM*DIM elements for matrix A then B, an opcode, starts the ALU,
// waits for completion and holds the result for display.
// Optional feature: define ENTRY_TIMEOUT_EN to add an idle timeout that
// returns the controller to its reset state while the user is typing.
// Ports:
//   clk, nrst            clock (rising edge), async active-low reset
//   keycode[8:0]         completed keypad code, valid with store_dig
//   store_dig            digit complete pulse
//   enter                enter command pulse
//   result_ready         compute command pulse
//   alu_done             ALU finished
//   wr_en/wr_sel/wr_addr/wr_data  register-file write port (sel 0=A, 1=B)
//   alu_op[1:0]          latched opcode
//   alu_start            one-cycle ALU start pulse
//   phase[2:0]           current state encoding
//   result_valid         high while showing the result
//   err                  one-cycle pulse on a rejected command
module matrix_entry_ctrl
  import matrix_pkg::*;
#(
  parameter int          DIM            = 3,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [8:0] keycode,
  input  logic       store_dig,
  input  logic       enter,
  input  logic       result_ready,
  input  logic       alu_done,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [3:0] wr_addr,
  output logic [8:0] wr_data,
  output logic [1:0] alu_op,
  output logic       alu_start,
  output logic [2:0] phase,
  output logic       result_valid,
  output logic       err
);

  localparam logic [ADDR_W-1:0] N = ADDR_W'(DIM * DIM);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [1:0]        alu_op_nx;
  logic              op_vld, op_vld_nx;
  logic              wr_en_nx, wr_sel_nx, err_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [8:0]        wr_data_nx;
  logic              timeout_hit;

`ifdef ENTRY_TIMEOUT_EN
  logic expired;
  logic tmr_clear;

  // Any user/ALU activity or state change counts as "not idle".
  assign tmr_clear = store_dig | enter | result_ready | alu_done |
                     (state_nx != state) | timeout_hit;

  entry_timer #(.LIMIT(TIMEOUT_CYCLES)) u_entry_timer (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (tmr_clear),
    .expired (expired)
  );

  assign timeout_hit = expired && is_entry_state(state);
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= LOAD_A;
      idx     <= '0;
      alu_op  <= ADD;
      op_vld  <= 1'b0;
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      alu_op  <= alu_op_nx;
      op_vld  <= op_vld_nx;
      wr_en   <= wr_en_nx;
      wr_sel  <= wr_sel_nx;
      wr_addr <= wr_addr_nx;
      wr_data <= wr_data_nx;
      err     <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    alu_op_nx  = alu_op;
    op_vld_nx  = op_vld;
    wr_en_nx   = 1'b0;
    wr_sel_nx  = wr_sel;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    err_nx     = 1'b0;

    case (state)
      LOAD_A, LOAD_B: begin
        // A digit always wins over a simultaneous enter.
        if (store_dig) begin
          if (idx < N) begin
            wr_en_nx   = 1'b1;
            wr_sel_nx  = (state == LOAD_B);
            wr_addr_nx = idx;
            wr_data_nx = keycode;
            idx_nx     = idx + ADDR_W'(1);
          end else begin
            err_nx = 1'b1;
          end
        end else if (enter) begin
          if (idx == N) begin
            idx_nx    = '0;
            op_vld_nx = 1'b0;
            state_nx  = (state == LOAD_A) ? LOAD_B : GET_OP;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      GET_OP: begin
        if (store_dig) begin
          if (keycode[1:0] == ADD || keycode[1:0] == SUB || keycode[1:0] == MUL) begin
            alu_op_nx = keycode[1:0];
            op_vld_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
        // Judged on the flag as it stood before this cycle's digit.
        if (result_ready) begin
          if (op_vld) begin
            state_nx = START;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (alu_done) begin
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (enter && !store_dig) begin
          state_nx  = LOAD_A;
          idx_nx    = '0;
          op_vld_nx = 1'b0;
        end
      end
      default: state_nx = LOAD_A;
    endcase

    if (timeout_hit) begin
      state_nx   = LOAD_A;
      idx_nx     = '0;
      alu_op_nx  = ADD;
      op_vld_nx  = 1'b0;
      wr_en_nx   = 1'b0;
      wr_sel_nx  = 1'b0;
      wr_addr_nx = '0;
      wr_data_nx = '0;
      err_nx     = 1'b1;
    end
  end

  assign phase        = state;
  assign alu_start    = (state == START);
  assign result_valid = (state == SHOW);

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Scoreboard bench for matrix_entry_ctrl (default build, DIM=3).
module tb_matrix_entry_ctrl;

  localparam int DIM = 3;
  localparam int N   = DIM * DIM;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [8:0] keycode = '0;
  logic       store_dig = 1'b0, enter = 1'b0, result_ready = 1'b0, alu_done = 1'b0;
  logic       wr_en, wr_sel, alu_start, result_valid, err;
  logic [3:0] wr_addr;
  logic [8:0] wr_data;
  logic [1:0] alu_op;
  logic [2:0] phase;

  matrix_entry_ctrl #(.DIM(DIM)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .keycode      (keycode),
    .store_dig    (store_dig),
    .enter        (enter),
    .result_ready (result_ready),
    .alu_done     (alu_done),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .alu_op       (alu_op),
    .alu_start    (alu_start),
    .phase        (phase),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    bit we;
    bit er;
    bit st;
    int sel;
    int addr;
    int data;
    int op;
  } ev_t;

  typedef struct {
    int cyc;
    int ph;
  } ph_t;

  ev_t ev_q[$];
  ph_t ph_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  // Reference model: user-visible entry progress.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_op    = 0;
  bit m_have  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  ev_t me;
  ph_t mp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        me = ev_q.pop_front();
        chk("wr_en", int'(wr_en), int'(me.we));
        chk("err", int'(err), int'(me.er));
        chk("alu_start", int'(alu_start), int'(me.st));
        if (me.we) begin
          chk("wr_sel", int'(wr_sel), me.sel);
          chk("wr_addr", int'(wr_addr), me.addr);
          chk("wr_data", int'(wr_data), me.data);
        end
        if (me.st) chk("alu_op", int'(alu_op), me.op);
      end else if (wr_en || err || alu_start) begin
        chk("unexpected_output", int'({wr_en, err, alu_start}), 0);
      end
      if (ph_q.size() > 0 && ph_q[0].cyc == cyc) begin
        mp = ph_q.pop_front();
        chk("phase", int'(phase), mp.ph);
        chk("result_valid", int'(result_valid), (mp.ph == 5) ? 1 : 0);
      end else begin
        chk("phase_tracking", (ph_q.size() > 0) ? ph_q[0].cyc : -1, cyc);
      end
    end
  end

  // Drive one cycle of inputs, predict its effect, advance to the next cycle.
  task automatic step(input bit sd, input bit en, input bit rr, input bit ad,
                      input logic [8:0] kc);
    ev_t e;
    ph_t p;
    bit  have_old;
    store_dig    = sd;
    enter        = en;
    result_ready = rr;
    alu_done     = ad;
    keycode      = kc;
    e.cyc = cyc + 1; e.we = 0; e.er = 0; e.st = 0;
    e.sel = 0; e.addr = 0; e.data = 0; e.op = 0;
    have_old = m_have;
    case (m_phase)
      0, 1: begin
        if (sd) begin
          if (m_cnt < N) begin
            e.we = 1; e.sel = m_phase; e.addr = m_cnt; e.data = int'(kc);
            m_cnt++;
          end else begin
            e.er = 1;
          end
        end else if (en) begin
          if (m_cnt == N) begin
            m_cnt = 0;
            m_phase++;
          end else begin
            e.er = 1;
          end
        end
      end
      2: begin
        if (sd) begin
          if (kc[1:0] == 2'b11) e.er = 1;
          else begin
            m_op = int'(kc[1:0]);
            m_have = 1;
          end
        end
        if (rr) begin
          if (have_old) begin
            m_phase = 3; e.st = 1; e.op = m_op;
          end else begin
            e.er = 1;
          end
        end
      end
      3: m_phase = 4;
      4: if (ad) m_phase = 5;
      5: if (en && !sd) begin
           m_phase = 0; m_cnt = 0; m_have = 0;
         end
      default: m_phase = 0;
    endcase
    if (e.we || e.er || e.st) ev_q.push_back(e);
    p.cyc = cyc + 1;
    p.ph  = m_phase;
    ph_q.push_back(p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 9'd0);
  endtask

  // Assert reset for the current cycle and the next edge.
  task automatic do_reset();
    ph_t p;
    ev_t t;
    nrst = 1'b0;
    store_dig = 0; enter = 0; result_ready = 0; alu_done = 0; keycode = '0;
    while (ev_q.size() > 0 && ev_q[$].cyc >= cyc) t = ev_q.pop_back();
    while (ph_q.size() > 0 && ph_q[$].cyc >= cyc) p = ph_q.pop_back();
    m_phase = 0; m_cnt = 0; m_op = 0; m_have = 0;
    p.cyc = cyc; p.ph = 0;
    ph_q.push_back(p);
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_sel", int'(wr_sel), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_alu_start", int'(alu_start), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #1;
    p.cyc = cyc; p.ph = 0;
    ph_q.push_back(p);
    nrst = 1'b1;
  endtask

  task automatic fill_and_enter();
    for (int i = 0; i < N; i++) step(1, 0, 0, 0, 9'($urandom_range(0, 511)));
    step(0, 1, 0, 0, 9'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    // A: five digits, early enter, four more, enter -> LOAD_B
    for (int k = 1; k <= 5; k++) step(1, 0, 0, 0, 9'(k));
    step(0, 1, 0, 0, 9'd0);
    for (int k = 6; k <= 9; k++) step(1, 0, 0, 0, 9'(k));
    step(1, 0, 0, 0, 9'd77);
    step(0, 1, 0, 0, 9'd0);

    // B: eight digits, then digit+enter together at idx 8
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 9'(100 + k));
    step(1, 1, 0, 0, 9'd300);
    step(0, 1, 0, 0, 9'd0);

    // GET_OP: compute without opcode, bad opcode, good opcode, compute
    step(0, 0, 1, 0, 9'd0);
    step(1, 0, 0, 0, 9'h003);
    step(1, 0, 0, 0, 9'h002);
    step(0, 0, 1, 0, 9'd0);
    idle(19);
    step(0, 0, 0, 1, 9'd0);
    idle(2);
    step(0, 0, 1, 0, 9'd0);
    step(0, 0, 0, 1, 9'd0);
    step(0, 1, 0, 0, 9'd0);

    // Second pass: alu_done outside WAIT, then reset while waiting
    step(0, 0, 0, 1, 9'd0);
    fill_and_enter();
    fill_and_enter();
    step(1, 0, 0, 0, 9'h001);
    step(0, 0, 1, 0, 9'd0);
    idle(3);
    do_reset();
    step(0, 0, 0, 1, 9'd0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 12,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
             9'($urandom_range(0, 511)));
      end
    end

    idle(3);
    chk("queue_drained", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
